hack_boot_rom_loader: RTL and testbench



---
 rtl/hack_boot_rom_loader_pkg.sv | 24 ++
 rtl/hack_rom_ram.sv | 30 +++
 rtl/hack_boot_rom_loader.sv | 141 ++++++++++++++
 tb/tb_hack_boot_rom_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_boot_rom_loader_pkg.sv
// Shared definitions for the Hack boot ROM loader and the CPU top level.
// Provides the loader state encoding, the word/address width constants,
// and a helper that identifies the byte-accepting (load) states.
package hack_boot_rom_loader_pkg;

   localparam int HACK_WORD_W = 16;
   localparam int ROM_ADDR_W  = 15;

   typedef enum logic [2:0] {
      LEN_HI,
      LEN_LO,
      DAT_HI,
      DAT_LO,
      SUM_HI,
      SUM_LO,
      RUN,
      ERR
   } load_state_t;

   function automatic logic is_load_state(input load_state_t s);
      return (s != RUN) && (s != ERR);
   endfunction

endpackage

// File: rtl/hack_rom_ram.sv
// Instruction ROM storage: 2**ADDR_W x 16 words, written by the boot loader.
// Ports:
//   clk            write clock
//   we/waddr/wdata synchronous write port
//   raddr/rdata    asynchronous read port (zero-latency fetch)
// No reset: contents survive loader reset and reload.
module hack_rom_ram
   import hack_boot_rom_loader_pkg::*;
#(
   parameter int ADDR_W = ROM_ADDR_W
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      waddr,
   input  logic [HACK_WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0]      raddr,
   output logic [HACK_WORD_W-1:0] rdata
);

   logic [HACK_WORD_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hack_boot_rom_loader.sv
// Boot ROM loader for the Hack CPU. Receives a big-endian image stream
// (LEN, N data words, SUM), writes it into the instruction ROM, verifies the
// checksum and releases the CPU from reset once the image is good.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   byte_data/valid/ready   image byte stream handshake
//   reload                  restart loading while in RUN
//   pc / instruction        combinational fetch port for the CPU
//   cpu_reset, loaded, error status, registered
//   word_count              N of the last accepted header
//
// state  | meaning
// LEN_HI | waiting for length high byte
// LEN_LO | waiting for length low byte, range-check N
// DAT_HI | waiting for data word high byte
// DAT_LO | waiting for data word low byte, write ROM
// SUM_HI | waiting for checksum high byte
// SUM_LO | waiting for checksum low byte, compare
// RUN    | image valid, CPU running
// ERR    | bad header or checksum, left only by reset
module hack_boot_rom_loader
   import hack_boot_rom_loader_pkg::*;
#(
   parameter int ADDR_W = ROM_ADDR_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             byte_data,
   input  logic                   byte_valid,
   output logic                   byte_ready,
   input  logic                   reload,
   input  logic [ADDR_W-1:0]      pc,
   output logic [HACK_WORD_W-1:0] instruction,
   output logic                   cpu_reset,
   output logic                   loaded,
   output logic                   error,
   output logic [15:0]            word_count
);

   localparam int          WA_W      = ADDR_W + 1;
   localparam logic [16:0] MAX_WORDS = 17'(2**ADDR_W);

   load_state_t state, state_nxt;

   logic [7:0]             len_hi;
   logic [7:0]             dat_hi;
   logic [7:0]             sum_hi;
   // One extra bit so a full-depth image does not wrap the write pointer.
   logic [WA_W-1:0]        wr_addr;
   logic [WA_W:0]          wr_addr_inc;
   logic [15:0]            sum;
   logic [15:0]            len_word;
   logic [15:0]            dat_word;
   logic                   accept;
   logic                   len_bad;
   logic                   last_word;
   logic                   rom_we;
   logic [HACK_WORD_W-1:0] rom_rdata;

   assign byte_ready  = is_load_state(state) && !reset;
   assign accept      = byte_valid && byte_ready;
   assign len_word    = {len_hi, byte_data};
   assign dat_word    = {dat_hi, byte_data};
   assign len_bad     = (len_word == 16'd0) || ({1'b0, len_word} > MAX_WORDS);
   assign wr_addr_inc = {1'b0, wr_addr} + 1'b1;
   assign last_word   = (32'(wr_addr_inc) == 32'(word_count));

   always_comb begin
      state_nxt = state;
      rom_we    = 1'b0;
      case (state)
         LEN_HI: if (accept) state_nxt = LEN_LO;
         LEN_LO: if (accept) state_nxt = len_bad ? ERR : DAT_HI;
         DAT_HI: if (accept) state_nxt = DAT_LO;
         DAT_LO: begin
            if (accept) begin
               rom_we    = 1'b1;
               state_nxt = last_word ? SUM_HI : DAT_HI;
            end
         end
         SUM_HI: if (accept) state_nxt = SUM_LO;
         SUM_LO: if (accept) state_nxt = ({sum_hi, byte_data} == sum) ? RUN : ERR;
         RUN:    if (reload) state_nxt = LEN_HI;
         default: state_nxt = state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= LEN_HI;
         cpu_reset  <= 1'b1;
         loaded     <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
         wr_addr    <= '0;
         sum        <= '0;
         len_hi     <= '0;
         dat_hi     <= '0;
         sum_hi     <= '0;
      end else begin
         state     <= state_nxt;
         // Status decoded from next state so cpu_reset drops on the SUM_LO edge.
         cpu_reset <= (state_nxt != RUN);
         loaded    <= (state_nxt == RUN);
         error     <= (state_nxt == ERR);
         if (accept) begin
            case (state)
               LEN_HI: len_hi <= byte_data;
               LEN_LO: begin
                  if (!len_bad) begin
                     word_count <= len_word;
                     wr_addr    <= '0;
                     sum        <= '0;
                  end
               end
               DAT_HI: dat_hi <= byte_data;
               DAT_LO: begin
                  sum     <= sum + dat_word;
                  wr_addr <= wr_addr + 1'b1;
               end
               SUM_HI: sum_hi <= byte_data;
               default: ;
            endcase
         end
      end
   end

   hack_rom_ram #(
      .ADDR_W (ADDR_W)
   ) u_rom (
      .clk   (clk),
      .we    (rom_we),
      .waddr (wr_addr[ADDR_W-1:0]),
      .wdata (dat_word),
      .raddr (pc),
      .rdata (rom_rdata)
   );

   assign instruction = (32'(pc) < 32'(word_count)) ? rom_rdata : '0;

endmodule

// File: tb/tb_hack_boot_rom_loader.sv
module tb_hack_boot_rom_loader;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    byte_data = 8'h00;
   logic          byte_valid = 1'b0;
   logic          reload = 1'b0;
   logic [AW-1:0] pc = '0;
   logic          byte_ready;
   logic [15:0]   instruction;
   logic          cpu_reset;
   logic          loaded;
   logic          error;
   logic [15:0]   word_count;

   hack_boot_rom_loader #(.ADDR_W(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .byte_data   (byte_data),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .reload      (reload),
      .pc          (pc),
      .instruction (instruction),
      .cpu_reset   (cpu_reset),
      .loaded      (loaded),
      .error       (error),
      .word_count  (word_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode 0 = loading, 1 = running, 2 = error.
   // Progress is tracked as a count of bytes consumed in the current image.
   int          m_mode = 0;
   int          m_idx = 0;
   int          m_n = 0;
   logic [15:0] m_wc = '0;
   logic [7:0]  m_hi = '0;
   logic [15:0] m_rom [DEPTH];
   bit          m_known [DEPTH];
   bit          m_live = 0;

   task automatic model_byte(input logic [7:0] b);
      logic [15:0] s;
      int n;
      if (m_idx == 0) begin
         m_hi = b;
      end else if (m_idx == 1) begin
         n = int'({m_hi, b});
         if (n == 0 || n > DEPTH) m_mode = 2;
         else begin
            m_n  = n;
            m_wc = 16'(n);
         end
      end else if (m_idx < 2 + 2 * m_n) begin
         if ((m_idx % 2) == 0) m_hi = b;
         else begin
            m_rom[(m_idx - 3) / 2]   = {m_hi, b};
            m_known[(m_idx - 3) / 2] = 1'b1;
         end
      end else if (m_idx == 2 + 2 * m_n) begin
         m_hi = b;
      end else begin
         s = '0;
         for (int k = 0; k < m_n; k++) s = s + m_rom[k];
         m_mode = ({m_hi, b} == s) ? 1 : 2;
      end
      m_idx++;
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_live = 1'b1;
         m_mode = 0;
         m_idx  = 0;
         m_wc   = '0;
      end else if (m_live) begin
         if (m_mode == 0 && byte_valid) model_byte(byte_data);
         else if (m_mode == 1 && reload) begin
            m_mode = 0;
            m_idx  = 0;
         end
      end
   end

   // Per-cycle compare, away from the active edge.
   int   dut_runs = 0;
   logic loaded_q = 1'b0;
   always @(negedge clk) begin
      #3;
      if (m_live) begin
         chk("byte_ready", byte_ready, (m_mode == 0) && !reset);
         chk("cpu_reset", cpu_reset, m_mode != 1);
         chk("loaded", loaded, m_mode == 1);
         chk("error", error, m_mode == 2);
         chk("word_count", word_count, m_wc);
         if (32'(pc) >= 32'(m_wc)) chk("instr_oob", instruction, 0);
         else if (m_known[pc]) chk("instr", instruction, m_rom[pc]);
      end
      if (loaded && !loaded_q) dut_runs++;
      loaded_q = loaded;
   end

   logic [7:0]  img [$];
   logic [15:0] w_arr [DEPTH];

   task automatic make_img(input int n, input bit bad_sum);
      logic [15:0] s;
      s = '0;
      img.delete();
      img.push_back(8'(n >> 8));
      img.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
         img.push_back(w_arr[i][15:8]);
         img.push_back(w_arr[i][7:0]);
         s = s + w_arr[i];
      end
      if (bad_sum) s = s ^ 16'h0001;
      img.push_back(s[15:8]);
      img.push_back(s[7:0]);
   endtask

   task automatic cyc(input bit rnd_reload);
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      pc         = AW'($urandom);
      reload     = rnd_reload && ($urandom_range(0, 7) == 0);
   endtask

   task automatic send_all(input int maxgap, input bit rnd_reload);
      foreach (img[i]) begin
         repeat ($urandom_range(0, maxgap)) cyc(rnd_reload);
         @(negedge clk);
         byte_valid = 1'b1;
         byte_data  = img[i];
         pc         = AW'($urandom);
         reload     = 1'b0;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      #3;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      byte_valid = 1'b0;
      reload = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic peek(input int addr, input logic [15:0] exp, input string name);
      @(negedge clk);
      byte_valid = 1'b0;
      reload = 1'b0;
      pc = AW'(addr);
      #3;
      chk(name, instruction, exp);
   endtask

   task automatic pulse_reload();
      @(negedge clk);
      byte_valid = 1'b0;
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      #3;
   endtask

   int runs0;

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #3;
      chk("reset_cpu_reset", cpu_reset, 1);
      chk("reset_word_count", word_count, 0);
      chk("reset_byte_ready", byte_ready, 1);

      // Basic load.
      w_arr[0] = 16'h0005;
      w_arr[1] = 16'hEC10;
      make_img(2, 1'b0);
      chk("t1_img_sum_hi", img[6], 8'hEC);
      chk("t1_img_sum_lo", img[7], 8'h15);
      send_all(0, 1'b0);
      chk("t1_cpu_reset_fall", cpu_reset, 0);
      chk("t1_loaded", loaded, 1);
      chk("t1_word_count", word_count, 2);
      peek(0, 16'h0005, "t1_pc0");
      peek(1, 16'hEC10, "t1_pc1");
      peek(2, 16'h0000, "t1_pc2");

      // Bad checksum.
      do_reset();
      make_img(2, 1'b1);
      send_all(0, 1'b0);
      chk("t2_error", error, 1);
      chk("t2_cpu_reset", cpu_reset, 1);
      chk("t2_byte_ready", byte_ready, 0);
      make_img(2, 1'b0);
      send_all(0, 1'b0);
      pulse_reload();
      chk("t2_error_sticky", error, 1);
      chk("t2_ready_sticky", byte_ready, 0);
      do_reset();
      #3;
      chk("t2_error_cleared", error, 0);

      // Header bounds.
      img.delete(); img.push_back(8'h00); img.push_back(8'h00);
      send_all(0, 1'b0);
      chk("t3_len0_error", error, 1);
      do_reset();
      img.delete(); img.push_back(8'h00); img.push_back(8'h11);
      send_all(0, 1'b0);
      chk("t3_len17_error", error, 1);
      do_reset();
      for (int i = 0; i < DEPTH; i++) w_arr[i] = 16'($urandom);
      w_arr[15] = 16'hBEEF;
      make_img(16, 1'b0);
      send_all(0, 1'b0);
      chk("t3_len16_loaded", loaded, 1);
      chk("t3_len16_wc", word_count, 16);
      peek(15, 16'hBEEF, "t3_rom15");

      // Reset mid-load, after the high byte of word 1.
      do_reset();
      img.delete();
      img.push_back(8'h00); img.push_back(8'h02);
      img.push_back(8'h00); img.push_back(8'h05); img.push_back(8'hEC);
      send_all(0, 1'b0);
      @(negedge clk);
      reset = 1'b1; byte_valid = 1'b1; byte_data = 8'h10;
      @(negedge clk);
      reset = 1'b0; byte_valid = 1'b0;
      #3;
      chk("t4_word_count", word_count, 0);
      chk("t4_cpu_reset", cpu_reset, 1);
      chk("t4_byte_ready", byte_ready, 1);
      w_arr[0] = 16'h0005;
      w_arr[1] = 16'hEC10;
      make_img(2, 1'b0);
      send_all(0, 1'b0);
      chk("t4_loaded", loaded, 1);
      peek(1, 16'hEC10, "t4_pc1");

      // Throttled stream.
      do_reset();
      runs0 = dut_runs;
      send_all(3, 1'b0);
      repeat (4) cyc(1'b0);
      chk("t5_single_run", dut_runs - runs0, 1);
      peek(0, 16'h0005, "t5_pc0");
      peek(1, 16'hEC10, "t5_pc1");
      peek(2, 16'h0000, "t5_pc2");

      // Reload in RUN.
      pulse_reload();
      chk("t6_cpu_reset", cpu_reset, 1);
      chk("t6_byte_ready", byte_ready, 1);
      w_arr[0] = 16'h1234;
      make_img(1, 1'b0);
      send_all(0, 1'b0);
      chk("t6_loaded", loaded, 1);
      peek(0, 16'h1234, "t6_pc0");
      peek(1, 16'h0000, "t6_pc1");

      // Randomized images, gaps, ignored reloads and bad checksums.
      for (int it = 0; it < 30; it++) begin
         for (int i = 0; i < DEPTH; i++) w_arr[i] = 16'($urandom);
         make_img($urandom_range(1, DEPTH), $urandom_range(0, 4) == 0);
         send_all($urandom_range(0, 3), 1'b1);
         repeat ($urandom_range(2, 6)) cyc(1'b0);
         if (error || $urandom_range(0, 9) == 0) do_reset();
         else pulse_reload();
      end
      repeat (3) cyc(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
